// File: rtl/load_pkg.sv
// Shared encodings for the load unit: load kinds, FSM states, exception codes
// and the accept-time legality check.
package load_pkg;

  typedef enum logic [2:0] {
    LdLw  = 3'b000,
    LdLh  = 3'b001,
    LdLhu = 3'b010,
    LdLb  = 3'b011,
    LdLbu = 3'b100
  } ld_type_e;

  typedef enum logic [1:0] {
    StIdle = 2'b00,
    StReq  = 2'b01,
    StResp = 2'b10,
    StErr  = 2'b11
  } state_e;

  typedef enum logic [1:0] {
    ExcNone     = 2'b00,
    ExcMisalign = 2'b01,
    ExcIllegal  = 2'b10,
    ExcTimeout  = 2'b11
  } exc_e;

  // Illegal type wins over misalignment.
  function automatic exc_e decode_exc(input logic [2:0] ld_type, input logic [1:0] addr_lo);
    exc_e exc;
    exc = ExcNone;
    if (ld_type > LdLbu) begin
      exc = ExcIllegal;
    end else if (ld_type == LdLw && addr_lo != 2'b00) begin
      exc = ExcMisalign;
    end else if ((ld_type == LdLh || ld_type == LdLhu) && addr_lo[0]) begin
      exc = ExcMisalign;
    end
    return exc;
  endfunction

endpackage

// File: rtl/load_extend.sv
// Byte/halfword lane selection and sign/zero extension of a memory word.
module load_extend
  import load_pkg::*;
(
  input  logic [31:0] word_i,
  input  logic [2:0]  ld_type_i,
  input  logic [1:0]  addr_i,
  output logic [31:0] data_o
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    unique case (addr_i)
      2'b00: byte_sel = word_i[7:0];
      2'b01: byte_sel = word_i[15:8];
      2'b10: byte_sel = word_i[23:16];
      2'b11: byte_sel = word_i[31:24];
      default: byte_sel = 8'h00;
    endcase
    half_sel = addr_i[1] ? word_i[31:16] : word_i[15:0];

    case (ld_type_i)
      LdLw:    data_o = word_i;
      LdLh:    data_o = {{16{half_sel[15]}}, half_sel};
      LdLhu:   data_o = {16'h0000, half_sel};
      LdLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
      LdLbu:   data_o = {24'h000000, byte_sel};
      default: data_o = 32'h0000_0000;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// Load unit: accepts one load at a time, reads the aligned word from data memory,
// extends it, and returns a one-cycle result or an error code.
module load_unit
  import load_pkg::*;
#(
  parameter int unsigned TIMEOUT = 255
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        ld_valid,
  input  logic [2:0]  ld_type,
  input  logic [31:0] ld_addr,
  input  logic [31:0] ld_pc,
  output logic        ld_ready,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic [31:0] rd_pc,
  output logic [1:0]  exc_code,
  output logic        mem_req,
  output logic [31:0] mem_addr,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  localparam logic [7:0] CntLast = 8'(TIMEOUT - 1);

  state_e      state_q, state_d;
  exc_e        exc_q, exc_d;
  exc_e        acc_exc;
  logic [2:0]  type_q, type_d;
  logic [31:0] addr_q, addr_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] data_q, data_d;
  logic [7:0]  cnt_q, cnt_d;
  logic [31:0] ext_data;

  load_extend u_extend (
    .word_i   (mem_rdata),
    .ld_type_i(type_q),
    .addr_i   (addr_q[1:0]),
    .data_o   (ext_data)
  );

  always_comb begin
    state_d = state_q;
    exc_d   = exc_q;
    type_d  = type_q;
    addr_d  = addr_q;
    pc_d    = pc_q;
    data_d  = data_q;
    cnt_d   = cnt_q;
    acc_exc = decode_exc(ld_type, ld_addr[1:0]);
    unique case (state_q)
      StIdle: begin
        if (ld_valid) begin
          type_d  = ld_type;
          addr_d  = ld_addr;
          pc_d    = ld_pc;
          data_d  = 32'h0000_0000;
          cnt_d   = 8'h00;
          exc_d   = acc_exc;
          state_d = (acc_exc == ExcNone) ? StReq : StErr;
        end
      end
      StReq: begin
        if (mem_ack) begin
          data_d  = ext_data;
          state_d = StResp;
        end else if (cnt_q == CntLast) begin
          exc_d   = ExcTimeout;
          state_d = StErr;
        end else begin
          cnt_d = cnt_q + 8'h01;
        end
      end
      StResp, StErr: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      exc_q   <= ExcNone;
      type_q  <= 3'b000;
      addr_q  <= 32'h0000_0000;
      pc_q    <= 32'h0000_0000;
      data_q  <= 32'h0000_0000;
      cnt_q   <= 8'h00;
    end else begin
      state_q <= state_d;
      exc_q   <= exc_d;
      type_q  <= type_d;
      addr_q  <= addr_d;
      pc_q    <= pc_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
    end
  end

  // Result fields are forced to zero outside the single result cycle.
  assign ld_ready = (state_q == StIdle);
  assign mem_req  = (state_q == StReq);
  assign mem_addr = mem_req ? {addr_q[31:2], 2'b00} : 32'h0000_0000;
  assign rd_valid = (state_q == StResp) || (state_q == StErr);
  assign rd_data  = (state_q == StResp) ? data_q : 32'h0000_0000;
  assign rd_pc    = rd_valid ? pc_q : 32'h0000_0000;
  assign exc_code = (state_q == StErr) ? exc_q : ExcNone;

endmodule

// File: tb/tb_load_unit.sv
// Scoreboard bench for load_unit: stimulus pushes expected results, a monitor
// pops and compares on every rd_valid, and a memory model answers mem_req.
module tb_load_unit;

  localparam int unsigned TO = 4;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        ld_valid = 1'b0;
  logic [2:0]  ld_type = 3'b000;
  logic [31:0] ld_addr = 32'h0;
  logic [31:0] ld_pc = 32'h0;
  logic        ld_ready;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic [31:0] rd_pc;
  logic [1:0]  exc_code;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack = 1'b0;
  logic [31:0] mem_rdata = 32'h0;

  load_unit #(.TIMEOUT(TO)) dut (
    .clk      (clk),
    .reset    (reset),
    .ld_valid (ld_valid),
    .ld_type  (ld_type),
    .ld_addr  (ld_addr),
    .ld_pc    (ld_pc),
    .ld_ready (ld_ready),
    .rd_valid (rd_valid),
    .rd_data  (rd_data),
    .rd_pc    (rd_pc),
    .exc_code (exc_code),
    .mem_req  (mem_req),
    .mem_addr (mem_addr),
    .mem_ack  (mem_ack),
    .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic [31:0] pc;
    logic [1:0]  exc;
    int          lat;
    int          mem_cycles;
    int          acc_cyc;
  } exp_t;

  exp_t        sb[$];
  int          errors = 0;
  int          checks = 0;
  int          cyc = 0;
  int          ack_delay = 0;
  int          req_n = 0;
  int          mem_cnt = 0;
  logic        force_ack = 1'b0;
  logic [31:0] mem_word = 32'h0;
  logic [31:0] exp_addr = 32'h0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference extension from the load rules, done with shifts and arithmetic.
  function automatic logic [31:0] ref_ext(input logic [2:0] t, input logic [31:0] a,
                                          input logic [31:0] w);
    logic [31:0] b;
    logic [31:0] h;
    logic [1:0]  lo;
    lo = a[1:0];
    b = (w >> (8 * int'(lo))) & 32'h0000_00FF;
    h = (w >> (16 * int'(lo[1]))) & 32'h0000_FFFF;
    case (t)
      3'd0: return w;
      3'd1: return (h >= 32'h8000) ? h - 32'h0001_0000 : h;
      3'd2: return h;
      3'd3: return (b >= 32'h80) ? b - 32'h0000_0100 : b;
      3'd4: return b;
      default: return 32'h0;
    endcase
  endfunction

  // Memory model: ack after ack_delay REQ cycles without ack.
  always @(negedge clk) begin
    if (mem_req) begin
      mem_ack   = force_ack || (req_n == ack_delay);
      mem_rdata = mem_ack ? mem_word : $urandom;
      req_n++;
    end else begin
      mem_ack   = force_ack;
      mem_rdata = force_ack ? 32'hDEAD_BEEF : 32'h0;
      req_n     = 0;
    end
  end

  // Monitor.
  always @(negedge clk) begin
    exp_t e;
    if (mem_req) begin
      mem_cnt++;
      check("mem_addr", mem_addr, exp_addr);
    end
    if (rd_valid) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL spurious_rd_valid: got rd_valid=1 expected no result (t=%0t)", $time);
      end else begin
        e = sb.pop_front();
        check("rd_data", rd_data, e.data);
        check("rd_pc", rd_pc, e.pc);
        check("exc_code", 32'(exc_code), 32'(e.exc));
        check("latency", 32'(cyc - e.acc_cyc + 1), 32'(e.lat));
        check("mem_req_cycles", 32'(mem_cnt), 32'(e.mem_cycles));
      end
    end else begin
      check("quiet_outputs", rd_data | rd_pc | 32'(exc_code), 32'h0);
    end
  end

  // Called at a negedge with the DUT idle; returns at a negedge with it idle again.
  task automatic do_load(input logic [2:0] t, input logic [31:0] a, input logic [31:0] w,
                         input int d);
    exp_t       e;
    logic [1:0] ex;
    int         n;
    ex = 2'd0;
    if (t > 3'd4) ex = 2'd2;
    else if ((t == 3'd0 && a[1:0] != 2'b00) || ((t == 3'd1 || t == 3'd2) && a[0])) ex = 2'd1;
    e.pc = $urandom;
    if (ex != 2'd0) begin
      e.data = 32'h0; e.exc = ex; e.lat = 1; e.mem_cycles = 0;
    end else if (d >= int'(TO)) begin
      e.data = 32'h0; e.exc = 2'd3; e.lat = int'(TO) + 1; e.mem_cycles = int'(TO);
    end else begin
      e.data = ref_ext(t, a, w); e.exc = 2'd0; e.lat = d + 2; e.mem_cycles = d + 1;
    end
    check("ld_ready", 32'(ld_ready), 32'h1);
    ack_delay = d;
    mem_word  = w;
    exp_addr  = {a[31:2], 2'b00};
    mem_cnt   = 0;
    ld_valid  = 1'b1;
    ld_type   = t;
    ld_addr   = a;
    ld_pc     = e.pc;
    e.acc_cyc = cyc + 1;
    sb.push_back(e);
    @(negedge clk);
    ld_valid = 1'b0;
    ld_type  = 3'($urandom);
    ld_addr  = $urandom;
    ld_pc    = $urandom;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(negedge clk);
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL no_result: got no rd_valid within 40 cycles expected one");
      sb.delete();
    end
    @(negedge clk);
  endtask

  initial begin
    logic [2:0]  t;
    logic [31:0] a;
    repeat (3) @(negedge clk);
    check("reset_ld_ready", 32'(ld_ready), 32'h1);
    check("reset_mem_req", 32'(mem_req), 32'h0);
    check("reset_rd_valid", 32'(rd_valid), 32'h0);
    check("reset_mem_addr", mem_addr, 32'h0);
    reset = 1'b1;
    @(negedge clk);

    do_load(3'd0, 32'h100, 32'h1234_5678, 3);
    do_load(3'd3, 32'h103, 32'h80FF_7F01, 1);
    do_load(3'd4, 32'h103, 32'h80FF_7F01, 0);
    do_load(3'd1, 32'h102, 32'h80FF_7F01, 2);
    do_load(3'd0, 32'h102, 32'hCAFE_F00D, 0);
    do_load(3'd1, 32'h101, 32'hCAFE_F00D, 0);
    do_load(3'd7, 32'h101, 32'hCAFE_F00D, 0);
    do_load(3'd0, 32'h200, 32'hCAFE_F00D, 1000);

    // Reset during the second REQ cycle, then a late ack.
    exp_addr  = 32'h300;
    ack_delay = 1000;
    ld_valid  = 1'b1;
    ld_type   = 3'd0;
    ld_addr   = 32'h300;
    ld_pc     = 32'h4444_0000;
    @(negedge clk);
    ld_valid = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    reset = 1'b1;
    force_ack = 1'b1;
    check("abort_ld_ready", 32'(ld_ready), 32'h1);
    check("abort_mem_req", 32'(mem_req), 32'h0);
    @(negedge clk);
    force_ack = 1'b0;
    check("abort_rd_valid", 32'(rd_valid), 32'h0);
    @(negedge clk);
    do_load(3'd0, 32'h304, 32'h0BAD_F00D, 1);

    for (int i = 0; i < 30; i++) begin
      t = ($urandom_range(0, 3) == 0) ? 3'($urandom_range(5, 7)) : 3'($urandom_range(0, 4));
      a = $urandom;
      if ($urandom_range(0, 2) != 0) begin
        if (t == 3'd0) a[1:0] = 2'b00;
        else a[0] = 1'b0;
      end
      do_load(t, a, $urandom, $urandom_range(0, 5));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got no end of test expected $finish before 200000");
    $fatal(1);
  end

endmodule
